// File: rtl/mfhwt_frame_sequencer.sv
// mfhwt_frame_sequencer: frame-level scheduler in front of the MFHWT datapath.
// Gates the pixel stream, tracks column/row, marks SOF/EOF, counts outgoing
// coefficients and reports frame completion or a drain timeout.
// Optional build macro: MFHWT_SEQ_CONTINUOUS_EN (chain frames without iStart).

module mfhwt_frame_sequencer #(
  parameter int unsigned IMG_W         = 320,
  parameter int unsigned IMG_H         = 240,
  parameter int unsigned COL_W         = 9,
  parameter int unsigned ROW_W         = 8,
  parameter int unsigned OUT_COUNT     = 19200,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iStart,
  input  logic             iPixel_valid,
  input  logic             iStall,
  input  logic             iOutput_ready,
  output logic             oPixel_ready,
  output logic             oData_ready,
  output logic             oSof,
  output logic             oEof,
  output logic [COL_W-1:0] oCol,
  output logic [ROW_W-1:0] oRow,
  output logic [OUT_W-1:0] oOut_count,
  output logic             oBusy,
  output logic             oFrame_done,
  output logic             oError
);

  localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [TMR_W-1:0] drain_tmr;
  logic [OUT_W-1:0] out_cnt_nxt;
  logic             cnt_en;
  logic             accept;
  logic             first_px;
  logic             last_px;
  logic             cnt_hit;
  logic             timeout;

  assign accept      = iPixel_valid & oPixel_ready;
  assign first_px    = (col_cnt == '0) && (row_cnt == '0);
  assign last_px     = (col_cnt == COL_W'(IMG_W - 1)) && (row_cnt == ROW_W'(IMG_H - 1));
  assign out_cnt_nxt = (cnt_en && (oOut_count != OUT_W'(OUT_COUNT)))
                       ? oOut_count + OUT_W'(1) : oOut_count;
  assign cnt_hit     = (out_cnt_nxt == OUT_W'(OUT_COUNT));
  assign timeout     = (state == S_DRAIN) && !iOutput_ready &&
                       (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1));

  // State register
  always_ff @(posedge iClk) begin
    if (!iReset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (accept && last_px) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt_hit || timeout) state_nxt = S_DONE;
`ifdef MFHWT_SEQ_CONTINUOUS_EN
      S_DONE:  state_nxt = oError ? S_IDLE : S_LOAD;
`else
      S_DONE:  state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state combinational controls: pixel gating and output-count enable
  always_comb begin
    oPixel_ready = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      S_RUN: begin
        oPixel_ready = ~iStall;
        cnt_en       = iOutput_ready;
      end
      S_DRAIN: cnt_en = iOutput_ready;
      default: ;
    endcase
  end

  // Registered strobes, position, counters and status flags
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      oData_ready <= 1'b0;
      oSof        <= 1'b0;
      oEof        <= 1'b0;
      oCol        <= '0;
      oRow        <= '0;
      oOut_count  <= '0;
      oBusy       <= 1'b0;
      oFrame_done <= 1'b0;
      oError      <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      drain_tmr   <= '0;
    end else begin
      oData_ready <= accept;
      oSof        <= accept & first_px;
      oEof        <= accept & last_px;
      oFrame_done <= (state_nxt == S_DONE);
      oBusy       <= (state_nxt != S_IDLE);
      case (state)
        S_LOAD: begin
          col_cnt    <= '0;
          row_cnt    <= '0;
          oCol       <= '0;
          oRow       <= '0;
          oOut_count <= '0;
          drain_tmr  <= '0;
          oError     <= 1'b0;
        end
        S_RUN: begin
          oOut_count <= out_cnt_nxt;
          if (accept) begin
            oCol <= col_cnt;
            oRow <= row_cnt;
            if (col_cnt == COL_W'(IMG_W - 1)) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + ROW_W'(1);
            end else begin
              col_cnt <= col_cnt + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          oOut_count <= out_cnt_nxt;
          if (iOutput_ready) drain_tmr <= '0;
          else               drain_tmr <= drain_tmr + TMR_W'(1);
          if (timeout && !cnt_hit) oError <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
